// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its PC register.
package fetch_stage_pkg;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;
    localparam logic [WORD_WIDTH-1:0] RESET_PC_VALUE = 32'hBFC0_0000;

    // Decode-slot occupancy: nothing, the word on the SRAM read port, or the hold buffer.
    typedef enum logic [1:0] {
        FETCH_EMPTY = 2'd0,
        FETCH_LIVE  = 2'd1,
        FETCH_HELD  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] instr;
        logic                  valid;
    } slot_out_t;

    // Maps the slot state onto what decode sees; EMPTY always presents a nop.
    function automatic slot_out_t slot_view(input fetch_state_e st,
                                            input logic [WORD_WIDTH-1:0] rdata,
                                            input logic [WORD_WIDTH-1:0] held);
        slot_out_t o;
        o.instr = ZERO_WORD;
        o.valid = 1'b0;
        case (st)
            FETCH_LIVE: begin
                o.instr = rdata;
                o.valid = 1'b1;
            end
            FETCH_HELD: begin
                o.instr = held;
                o.valid = 1'b1;
            end
            default: begin
                o.instr = ZERO_WORD;
                o.valid = 1'b0;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Fetch PC register: asynchronous reset to the boot vector, loads only when enabled.
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] RESET_PC = RESET_PC_VALUE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [WORD_WIDTH-1:0] d_i,
    output logic [WORD_WIDTH-1:0] q_o
);

    logic [WORD_WIDTH-1:0] pc_q;
    logic [WORD_WIDTH-1:0] pc_d;

    // Hold the PC unless a fetch is issued this cycle.
    always_comb begin
        pc_d = pc_q;
        if (en_i) begin
            pc_d = d_i;
        end
    end

    // PC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch plus the IF/ID boundary. The SRAM answers one cycle after the
// request, so a freshly fetched word is shown straight from the read port (LIVE);
// when decode stalls, that word is captured into hold_q (HELD) so it survives
// the SRAM port being idle or reused.
//
//   state       | meaning
//   FETCH_EMPTY | bubble in decode: instrD = 0, validD = 0
//   FETCH_LIVE  | decode sees inst_sram_rdata for the previous cycle's request
//   FETCH_HELD  | decode stalled; decode sees the captured word in hold_q
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] RESET_PC = RESET_PC_VALUE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] npc,
    input  logic                  stallF,
    input  logic                  stallD,
    input  logic                  flushD,
    output logic                  inst_sram_en,
    output logic [WORD_WIDTH-1:0] inst_sram_addr,
    input  logic [WORD_WIDTH-1:0] inst_sram_rdata,
    output logic [WORD_WIDTH-1:0] pcF,
    output logic [WORD_WIDTH-1:0] instrD,
    output logic [WORD_WIDTH-1:0] pcD,
    output logic                  validD
);

    logic                  issue;
    logic                  load_pcd;
    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [WORD_WIDTH-1:0] hold_q;
    logic [WORD_WIDTH-1:0] hold_d;
    logic [WORD_WIDTH-1:0] pcd_q;
    logic [WORD_WIDTH-1:0] pcd_d;
    slot_out_t             slot;

    // rst is folded in so no request leaves while reset is held.
    assign issue          = ~stallF & ~rst;
    assign inst_sram_en   = issue;
    assign inst_sram_addr = pcF;

    // A flushed fetch still advances the PC, but its PC never reaches decode.
    assign load_pcd = issue & ~stallD & ~flushD;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .en_i(issue),
        .d_i (npc),
        .q_o (pcF)
    );

    // Decode-slot next state and hold-buffer capture; flush beats stall.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (flushD) begin
            state_d = FETCH_EMPTY;
        end else if (stallD) begin
            if (state_q == FETCH_LIVE) begin
                state_d = FETCH_HELD;
                hold_d  = inst_sram_rdata;
            end
        end else begin
            state_d = issue ? FETCH_LIVE : FETCH_EMPTY;
        end
    end

    // pcD follows the fetch PC only when the word actually enters decode.
    always_comb begin
        pcd_d = pcd_q;
        if (load_pcd) begin
            pcd_d = pcF;
        end
    end

    // Slot state, hold buffer and decode PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_EMPTY;
            hold_q  <= ZERO_WORD;
            pcd_q   <= ZERO_WORD;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pcd_q   <= pcd_d;
        end
    end

    // Decode-facing instruction is combinational from slot state and the read port.
    always_comb begin
        slot = slot_view(state_q, inst_sram_rdata, hold_q);
    end

    assign instrD = slot.instr;
    assign validD = slot.valid;
    assign pcD    = pcd_q;

endmodule
